// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- the canonical bubble instruction.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: pipelined request/response port between fetch and instruction memory.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  // Fetch side issues requests and consumes responses.
  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  // Memory side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch_entry_t. Clear takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign rdata   = mem[rd_ptr];

  // Write an incoming entry into the slot at the write pointer.
  // NOTE: the storage array is deliberately left without reset; an entry is only ever
  // read after count shows it was written, so clearing it would only cost reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Advance pointers and track occupancy; clear empties the FIFO in one cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, pipelined imem port, prefetch FIFO and IF/ID register.
// Optional macro FETCH_PERF_EN adds bubble and redirect performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_d,
  input  logic                  pc_src,
  input  logic [DATA_WIDTH-1:0] pc_target,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] ins,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus_4d,
  output logic                  valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_bubble_cnt,
  output logic [31:0]           perf_redirect_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_f, resp_pc, target_aligned;
  logic [CW-1:0]         outstanding, drop_cnt, drop_next, fifo_count;
  logic                  room, accept, push, pop, fifo_empty, fifo_full;
  fetch_entry_t          head;

  assign target_aligned = {pc_target[DATA_WIDTH-1:2], 2'b00};
  assign room      = ({1'b0, fifo_count} + {1'b0, outstanding}) < SW'(FIFO_DEPTH);
  assign accept    = imem.imem_req & imem.imem_ready;
  // A response landing in the redirect cycle is already accounted for here.
  assign drop_next = outstanding - CW'(imem.imem_rvalid);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (pc_src),
    .wdata ('{pc: resp_pc, ins: imem.imem_rdata}),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // FSM next state: a redirect discards in-flight responses through DRAIN.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (pc_src) begin
      state_d = (drop_next != '0) ? DRAIN : FETCH;
    end else if (state_q == DRAIN && imem.imem_rvalid && drop_cnt == CW'(1)) begin
      state_d = FETCH;
    end
  end

  // FSM outputs: request issue, FIFO push and pop. Requests wait for reset release.
  always_comb begin
    imem.imem_req  = rst_n & (state_q == FETCH) & ~pc_src & room;
    imem.imem_addr = pc_f;
    push           = imem.imem_rvalid & (state_q == FETCH) & ~pc_src & ~fifo_full;
    pop            = ~pc_src & ~stall_d & ~fifo_empty;
  end

  // PC, response PC and in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem.imem_rvalid);
      if (pc_src) begin
        pc_f     <= target_aligned;
        resp_pc  <= target_aligned;
        drop_cnt <= drop_next;
      end else begin
        if (accept) pc_f <= pc_f + DATA_WIDTH'(4);
        if (push)   resp_pc <= resp_pc + DATA_WIDTH'(4);
        if (state_q == DRAIN && imem.imem_rvalid) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // IF/ID register: redirect forces a bubble even under stall; stall holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins        <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus_4d <= '0;
      valid_d    <= 1'b0;
    end else if (pc_src) begin
      ins     <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (!stall_d) begin
      if (!fifo_empty) begin
        ins        <= head.ins;
        pc_d       <= head.pc;
        pc_plus_4d <= head.pc + DATA_WIDTH'(4);
        valid_d    <= 1'b1;
      end else begin
        ins     <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Count bubble loads of IF/ID and redirect cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt   <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (pc_src || (!stall_d && fifo_empty)) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (pc_src) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with an in-order memory model and
// a sequence-level reference model; a second instance covers RESET_PC wrap-around.
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_d = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = '0;
  logic [31:0] ins, pc_d, pc_plus_4d;
  logic        valid_d;
  logic [31:0] ins_w, pc_d_w, pc_plus_4d_w;
  logic        valid_d_w;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_redirect_cnt, perf_bubble_w, perf_redirect_w;
`endif

  fetch_stage_if #(.DATA_WIDTH(32)) bus ();
  fetch_stage_if #(.DATA_WIDTH(32)) bus_w ();

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .pc_src(pc_src), .pc_target(pc_target),
    .imem(bus), .ins(ins), .pc_d(pc_d), .pc_plus_4d(pc_plus_4d), .valid_d(valid_d)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall_d(1'b0), .pc_src(1'b0), .pc_target(32'h0),
    .imem(bus_w), .ins(ins_w), .pc_d(pc_d_w), .pc_plus_4d(pc_plus_4d_w), .valid_d(valid_d_w)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(perf_bubble_w), .perf_redirect_cnt(perf_redirect_w)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction word stored at a given address in the memory model.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // ---------------- memory models ----------------
  logic [31:0] mq[$];
  logic        mem_hold = 1'b0;
  logic        acc_s = 1'b0, resp_s = 1'b0, acc_w_s = 1'b0;
  logic [31:0] acc_addr_s = '0, acc_addr_w_s = '0;

  // Capture this cycle's handshakes mid-cycle, where everything is settled.
  always @(negedge clk) begin
    acc_s        = bus.imem_req & bus.imem_ready;
    acc_addr_s   = bus.imem_addr;
    resp_s       = bus.imem_rvalid;
    acc_w_s      = bus_w.imem_req & bus_w.imem_ready;
    acc_addr_w_s = bus_w.imem_addr;
  end

  // Main memory: in-order queue, responses one cycle after acceptance unless held.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      mq.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end else begin
      if (resp_s && mq.size() != 0) void'(mq.pop_front());
      if (acc_s) mq.push_back(acc_addr_s);
      bus.imem_rvalid = !mem_hold && (mq.size() != 0);
      bus.imem_rdata  = bus.imem_rvalid ? instr_at(mq[0]) : '0;
    end
  end

  // Wrap-test memory: always ready, fixed one-cycle latency.
  always @(posedge clk) begin
    #2;
    bus_w.imem_rvalid = rst_n && acc_w_s;
    bus_w.imem_rdata  = instr_at(acc_addr_w_s);
  end

  // ---------------- reference model and per-cycle compare ----------------
  logic [31:0] exp_pc = '0, req_exp = '0, exp_w = WRAP_PC;
  logic        p_rstn = 1'b0, p_stall = 1'b0, p_src = 1'b0, p_req = 1'b0, p_ready = 1'b0;
  logic [31:0] p_tgt = '0, h_ins = '0, h_pc = '0, h_p4 = '0;
  logic        h_valid = 1'b0;
  int          bubbles = 0;

  // Decode must see consecutive PCs from the last redirect; requests walk the same stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc  = 32'h0;
      req_exp = 32'h0;
      exp_w   = WRAP_PC;
    end else begin
      if (p_rstn) begin
        if (p_src) begin
          check("redirect_valid", valid_d, 0);
          check("redirect_ins", ins, NOP_INSTR);
          exp_pc = {p_tgt[31:2], 2'b00};
        end else if (p_stall) begin
          check("stall_hold_ins", ins, h_ins);
          check("stall_hold_pc", pc_d, h_pc);
          check("stall_hold_valid", valid_d, h_valid);
        end else if (valid_d) begin
          check("seq_pc", pc_d, exp_pc);
          check("seq_ins", ins, instr_at(exp_pc));
          check("seq_pc4", pc_plus_4d, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
        end else begin
          check("bubble_ins", ins, NOP_INSTR);
        end
        if ((p_src || !p_stall) && !valid_d) bubbles++;
        if (valid_d_w) begin
          check("wrap_seq_pc", pc_d_w, exp_w);
          check("wrap_seq_ins", ins_w, instr_at(exp_w));
          check("wrap_seq_pc4", pc_plus_4d_w, exp_w + 32'd4);
          exp_w = exp_w + 32'd4;
        end
        if (p_req && !p_ready && !pc_src) check("req_held", bus.imem_req, 1);
      end
      if (bus.imem_req) check("req_addr", bus.imem_addr, req_exp);
      if (pc_src) req_exp = {pc_target[31:2], 2'b00};
      else if (bus.imem_req && bus.imem_ready) req_exp = req_exp + 32'd4;
    end
    p_rstn  = rst_n;
    p_stall = stall_d;
    p_src   = pc_src;
    p_tgt   = pc_target;
    p_req   = bus.imem_req;
    p_ready = bus.imem_ready;
    h_ins   = ins;
    h_pc    = pc_d;
    h_p4    = pc_plus_4d;
    h_valid = valid_d;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp);
    int k;
    k = 0;
    @(negedge clk);
    while (!valid_d && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_in_time"}, valid_d, 1);
    check(name, pc_d, exp);
  endtask

  initial begin
    bus.imem_ready   = 1'b1;
    bus_w.imem_ready = 1'b1;
    tick(2);

    // Reset values.
    @(negedge clk);
    check("rst_ins", ins, NOP_INSTR);
    check("rst_pc_d", pc_d, 0);
    check("rst_pc4", pc_plus_4d, 0);
    check("rst_valid", valid_d, 0);
    check("rst_req", bus.imem_req, 0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_addr_wrap", bus_w.imem_addr, WRAP_PC);

    // Cold start: accept at E1, FIFO write at E2, IF/ID load at E3.
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("cold_req", bus.imem_req, 1);
    check("cold_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    check("lat_e1_valid", valid_d, 0);
    @(negedge clk);
    check("lat_e2_valid", valid_d, 0);
    @(negedge clk);
    check("lat_e3_valid", valid_d, 1);
    check("lat_e3_pc", pc_d, 32'h0);
    check("lat_e3_pc4", pc_plus_4d, 32'h4);
    check("wrap_first_pc", pc_d_w, 32'hFFFF_FFFC);
    check("wrap_first_pc4", pc_plus_4d_w, 32'h0);
    @(negedge clk);
    check("thru_e4_pc", pc_d, 32'h4);
    check("wrap_second_pc", pc_d_w, 32'h0);
    @(negedge clk);
    check("thru_e5_pc", pc_d, 32'h8);
    tick(3);

    // Stall for five cycles: requests stop once DEPTH are in flight.
    stall_d = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_req_drop", bus.imem_req, 0);
    #1 check("stall_in_flight", (req_exp - exp_pc) >> 2, DEPTH);
    @(posedge clk);
    #1 stall_d = 1'b0;
    tick(6);

    // Backpressure: ready 1,0,0,1.
    bus.imem_ready = 1'b0;
    tick(2);
    bus.imem_ready = 1'b1;
    tick(4);

    // Redirect to 0x100 with three in flight, one returning in the redirect cycle.
    bus.imem_ready = 1'b0;
    tick(8);
    mem_hold = 1'b1;
    bus.imem_ready = 1'b1;
    tick(3);
    bus.imem_ready = 1'b0;
    mem_hold  = 1'b0;
    pc_src    = 1'b1;
    pc_target = 32'h100;
    @(posedge clk);
    #1;
    pc_src = 1'b0;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    check("drain1_req", bus.imem_req, 0);
    check("drain1_valid", valid_d, 0);
    @(negedge clk);
    check("drain2_req", bus.imem_req, 0);
    check("drain2_valid", valid_d, 0);
    @(negedge clk);
    check("post_drain_req", bus.imem_req, 1);
    check("post_drain_addr", bus.imem_addr, 32'h100);
    @(negedge clk);
    check("redir_lat1_valid", valid_d, 0);
    @(negedge clk);
    check("redir_lat2_valid", valid_d, 0);
    @(negedge clk);
    check("redir_valid", valid_d, 1);
    check("redir_pc", pc_d, 32'h100);
    tick(5);

    // Redirect under stall with unaligned target.
    stall_d   = 1'b1;
    pc_src    = 1'b1;
    pc_target = 32'h203;
    @(posedge clk);
    #1 pc_src = 1'b0;
    @(negedge clk);
    check("stall_redir_valid", valid_d, 0);
    check("stall_redir_ins", ins, NOP_INSTR);
    tick(2);
    stall_d = 1'b0;
    wait_valid("unaligned_restart_pc", 32'h200);
    tick(4);

`ifdef FETCH_PERF_EN
    @(negedge clk);
    #1;
    check("perf_redirect", perf_redirect_cnt, 2);
    check("perf_bubble", perf_bubble_cnt, bubbles);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
